program_loader: RTL

Serial-fed boot loader that writes a program image into the instruction memory before the single-cycle MIPS core runs. It accepts a byte stream (valid/ready), assembles little-endian 32-bit words, and issues one write per word on the program-memory write port using byte addresses. It holds the core in reset (`cpu_hold`) for the whole load and flags completion or error.

---
 rtl/program_loader_pkg.sv | 18 +
 rtl/byte_assembler.sv | 34 +++
 rtl/program_loader.sv | 105 ++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader.
// Optional macro PROGRAM_LOADER_CHECKSUM_EN enables the CHECK state in the top.
package program_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
        CHECK,
        DONE,
        ERROR
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_MIN        = 1;

endpackage

// File: rtl/byte_assembler.sv
// Assembles little-endian 32-bit words from a byte stream; word_valid is combinational
// on the transfer of the 4th byte so the caller can register the word that same edge.
module byte_assembler
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        i_byte_en,
    input  logic [7:0]  i_byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_shift;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
            r_shift <= '0;
        end else if (i_byte_en) begin
            r_count <= r_count + 1'b1;
            r_shift <= {i_byte_data, r_shift[31:8]};
        end
    end

    assign word_valid = i_byte_en && (r_count == CNT_W'(BYTES_PER_WORD - 1));
    assign word       = {i_byte_data, r_shift[31:8]};

endmodule

// File: rtl/program_loader.sv
// Serial boot loader: length word, then N data words written to program memory.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing mod-2^32 checksum word.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int MEMORY_DEPTH = 32,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            byte_valid,
    input  logic [7:0]                      byte_data,
    output logic                            byte_ready,
    output logic                            WriteEnable,
    output logic [DATA_WIDTH-1:0]           WriteAddress,
    output logic [DATA_WIDTH-1:0]           WriteData,
    output logic                            cpu_hold,
    output logic                            done,
    output logic                            error,
    output logic [$clog2(MEMORY_DEPTH+1)-1:0] loaded_words
);

    localparam int CNT_W = $clog2(MEMORY_DEPTH + 1);

    loader_state_t    r_state, w_next;
    logic [31:0]      r_len, r_word;
    logic [CNT_W-1:0] r_loaded;
    logic             w_start_ok, w_xfer, w_word_valid, w_last;
    logic [31:0]      w_word;

    assign w_start_ok = start && (r_state inside {IDLE, DONE, ERROR});
    assign byte_ready = r_state inside {LEN, DATA, CHECK};
    assign w_xfer     = byte_valid && byte_ready;
    assign w_last     = (32'(r_loaded) + 32'd1) >= r_len;

    byte_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (w_start_ok),
        .i_byte_en  (w_xfer),
        .i_byte_data(byte_data),
        .word       (w_word),
        .word_valid (w_word_valid)
    );

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [31:0] r_sum;

    always_ff @(posedge clk) begin
        if (reset || w_start_ok) r_sum <= '0;
        else if (r_state == WRITE) r_sum <= r_sum + r_word;
    end
`endif

    // NOTE: next state defaults to the current state first, so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE, DONE, ERROR: if (start) w_next = LEN;
            LEN: if (w_word_valid)
                w_next = (w_word < 32'(LEN_MIN) || w_word > 32'(MEMORY_DEPTH)) ? ERROR : DATA;
            DATA: if (w_word_valid) w_next = WRITE;
            WRITE: begin
                if (!w_last) w_next = DATA;
                else begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    w_next = CHECK;
`else
                    w_next = DONE;
`endif
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CHECK: if (w_word_valid) w_next = (w_word == r_sum) ? DONE : ERROR;
`endif
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_len    <= '0;
            r_word   <= '0;
            r_loaded <= '0;
        end else begin
            r_state <= w_next;
            if (w_start_ok) r_loaded <= '0;
            else if (r_state == WRITE) r_loaded <= r_loaded + 1'b1;
            if (r_state == LEN && w_word_valid) r_len <= w_word;
            if (r_state == DATA && w_word_valid) r_word <= w_word;
        end
    end

    // Outputs decode the state flop; address and data are zero outside WRITE.
    assign WriteEnable  = (r_state == WRITE);
    assign WriteAddress = WriteEnable ? (DATA_WIDTH'(r_loaded) << 2) : '0;
    assign WriteData    = WriteEnable ? DATA_WIDTH'(r_word) : '0;
    assign cpu_hold     = !(r_state inside {IDLE, DONE});
    assign done         = (r_state == DONE);
    assign error        = (r_state == ERROR);
    assign loaded_words = r_loaded;

endmodule
